gbf_refill_arbiter: RTL and testbench

- Shares one off-chip fill interface among NUM_REQ global-buffer (GBF) SRAMs.
- Each GBF raises a low-occupancy request. The block arbitrates round-robin and issues a burst command for the winner.
- It then streams BURST_LEN returned words into the winner's SRAM, keeping a wrapping write pointer per buffer.
- The per-buffer write address/enable outputs are the same signals the buffers' request generators consume.

---
 rtl/gbf_refill_arbiter.sv | 145 ++++++++++++++
 tb/tb_gbf_refill_arbiter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/gbf_refill_arbiter.sv
// Round-robin refill arbiter: shares one burst fill interface among NUM_REQ
// global-buffer SRAMs and streams each burst into the winner at its own wrapping pointer.

module gbf_wr_ptr #(
  parameter int AW = 7
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          inc,
  output logic [AW-1:0] ptr
);
  // DEPTH is a power of two, so natural overflow gives the DEPTH-1 -> 0 wrap.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)   ptr <= '0;
    else if (clr) ptr <= '0;
    else if (inc) ptr <= ptr + AW'(1);
endmodule

module gbf_refill_arbiter #(
  parameter  int NUM_REQ    = 3,
  parameter  int DEPTH      = 128,
  parameter  int BURST_LEN  = 16,
  parameter  int DATA_WIDTH = 64,
  localparam int AW         = $clog2(DEPTH),
  localparam int IW         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  Reset,
  input  logic [NUM_REQ-1:0]    Req,
  output logic                  IfCmdVld,
  input  logic                  IfCmdRdy,
  output logic [IW-1:0]         IfCmdId,
  input  logic                  IfDatVld,
  output logic                  IfDatRdy,
  input  logic [DATA_WIDTH-1:0] IfDat,
  output logic [NUM_REQ-1:0]    GbfEnWr,
  output logic [NUM_REQ*AW-1:0] GbfAddrWr,
  output logic [DATA_WIDTH-1:0] GbfDatWr,
  output logic [NUM_REQ-1:0]    Grant,
  output logic                  Busy
);
  localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  typedef enum logic [1:0] {IDLE, CMD, XFER, DONE} state_t;

  state_t                     state, state_nxt;
  logic [IW-1:0]              gnt_id, last_gnt, arb_id;
  logic                       arb_vld;
  logic [BW-1:0]              beat_cnt;
  logic                       beat, last_beat;
  logic [NUM_REQ-1:0][AW-1:0] wr_ptr;

  assign beat      = (state == XFER) && IfDatVld;
  assign last_beat = beat && (beat_cnt == BW'(BURST_LEN-1));
  assign IfCmdId   = gnt_id;

  // Round-robin: first requester at or after last_gnt+1, wrapping.
  always_comb begin
    int j;
    logic [IW-1:0] idx;
    j       = 0;
    idx     = '0;
    arb_vld = 1'b0;
    arb_id  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      j = int'(last_gnt) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      idx = IW'(j);
      if (!arb_vld && Req[idx]) begin
        arb_vld = 1'b1;
        arb_id  = idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)     state <= IDLE;
    else if (Reset) state <= IDLE;
    else            state <= state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (arb_vld)   state_nxt = CMD;
      CMD:     if (IfCmdRdy)  state_nxt = XFER;
      XFER:    if (last_beat) state_nxt = DONE;
      DONE:                   state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_comb begin
    IfCmdVld = (state == CMD);
    IfDatRdy = (state == XFER);
    Busy     = (state != IDLE);
  end

  // Write stage is one cycle behind the accepted beat.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      Grant    <= '0;
      gnt_id   <= '0;
      last_gnt <= IW'(NUM_REQ-1);
      beat_cnt <= '0;
      GbfEnWr  <= '0;
      GbfDatWr <= '0;
    end else if (Reset) begin
      Grant    <= '0;
      gnt_id   <= '0;
      last_gnt <= IW'(NUM_REQ-1);
      beat_cnt <= '0;
      GbfEnWr  <= '0;
      GbfDatWr <= '0;
    end else begin
      GbfEnWr <= beat ? Grant : '0;
      if (beat) GbfDatWr <= IfDat;
      case (state)
        IDLE: if (arb_vld) begin
          Grant  <= NUM_REQ'(1) << arb_id;
          gnt_id <= arb_id;
        end
        CMD:  if (IfCmdRdy) beat_cnt <= '0;
        XFER: if (beat) beat_cnt <= beat_cnt + BW'(1);
        DONE: begin
          last_gnt <= gnt_id;
          Grant    <= '0;
        end
        default: ;
      endcase
    end

  // Pointer has already advanced when the write fires, so show the pre-increment value then.
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_ptr
    gbf_wr_ptr #(.AW(AW)) u_ptr (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (Reset),
      .inc   (beat && Grant[i]),
      .ptr   (wr_ptr[i])
    );
    assign GbfAddrWr[i*AW +: AW] = GbfEnWr[i] ? wr_ptr[i] - AW'(1) : wr_ptr[i];
  end
endmodule

// File: tb/tb_gbf_refill_arbiter.sv
// Directed bench for gbf_refill_arbiter: write log and grant log collected at
// negedge, compared against hand-computed addresses, data and grant order.
module tb_gbf_refill_arbiter;
  localparam int N  = 3;
  localparam int AW = 7;
  localparam int DW = 64;
  localparam logic [63:0] BASE = 64'hC0DE_0000_0000_0000;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            Reset = 1'b0;
  logic [N-1:0]    Req = '0;
  logic            IfCmdRdy = 1'b1;
  logic            IfDatVld = 1'b0;
  logic [DW-1:0]   IfDat = '0;
  logic            IfCmdVld, IfDatRdy, Busy;
  logic [1:0]      IfCmdId;
  logic [N-1:0]    GbfEnWr, Grant;
  logic [N*AW-1:0] GbfAddrWr;
  logic [DW-1:0]   GbfDatWr;

  gbf_refill_arbiter dut (
    .clk(clk), .rst_n(rst_n), .Reset(Reset), .Req(Req),
    .IfCmdVld(IfCmdVld), .IfCmdRdy(IfCmdRdy), .IfCmdId(IfCmdId),
    .IfDatVld(IfDatVld), .IfDatRdy(IfDatRdy), .IfDat(IfDat),
    .GbfEnWr(GbfEnWr), .GbfAddrWr(GbfAddrWr), .GbfDatWr(GbfDatWr),
    .Grant(Grant), .Busy(Busy)
  );

  always #5 clk = ~clk;

  int          n_chk = 0, n_pass = 0;
  int          wb_q[$], wa_q[$], gnt_q[$];
  logic [63:0] wd_q[$];
  int          beat_ctr = 0;
  bit          vld_mode = 1'b0, tog = 1'b0, multi_hot = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // One cycle: observe outputs at negedge, then drive the next fill beat.
  task automatic step();
    @(negedge clk);
    if ($countones(GbfEnWr) > 1 || $countones(Grant) > 1) multi_hot = 1'b1;
    for (int i = 0; i < N; i++)
      if (GbfEnWr[i]) begin
        wb_q.push_back(i);
        wa_q.push_back(int'(GbfAddrWr[i*AW +: AW]));
        wd_q.push_back(GbfDatWr);
      end
    if (IfCmdVld && IfCmdRdy) gnt_q.push_back(int'(IfCmdId));
    tog      = ~tog;
    IfDatVld = vld_mode ? tog : 1'b1;
    IfDat    = BASE | 64'(beat_ctr);
    if (IfDatVld && IfDatRdy) beat_ctr++;
  endtask

  task automatic clear_logs();
    wb_q.delete(); wa_q.delete(); wd_q.delete(); gnt_q.delete();
    beat_ctr = 0;
  endtask

  task automatic wait_writes(input int n, input string tag);
    int k = 0;
    while (wb_q.size() < n && k < 2000) begin step(); k++; end
    chk({tag, "_wr_cnt"}, wb_q.size(), n);
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (Busy && k < 2000) begin step(); k++; end
    chk(tag, Busy, 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("rst_grant", Grant, 0);
    chk("rst_en", GbfEnWr, 0);
    chk("rst_cmdvld", IfCmdVld, 0);
    chk("rst_datrdy", IfDatRdy, 0);
    chk("rst_busy", Busy, 0);
    chk("rst_addr", GbfAddrWr, 0);
    chk("rst_dat", GbfDatWr, 0);

    // Buffer 0 alone for nine bursts: 1-cycle arbitration, wrap at 128.
    clear_logs();
    Req = 3'b001;
    chk("t1_pre_cmdvld", IfCmdVld, 0);
    step();
    chk("t1_cmdvld", IfCmdVld, 1);
    chk("t1_cmdid", IfCmdId, 0);
    chk("t1_grant", Grant, 3'b001);
    wait_writes(144, "t1");
    Req = '0;
    wait_idle("t1_idle");
    for (int k = 0; k < 144 && k < wb_q.size(); k++) begin
      chk($sformatf("t1_buf%0d", k), wb_q[k], 0);
      chk($sformatf("t1_addr%0d", k), wa_q[k], k % 128);
      chk($sformatf("t1_dat%0d", k), wd_q[k], BASE | 64'(k));
    end
    chk("t1_ptr0", GbfAddrWr[0 +: AW], 16);
    chk("t1_ptr1", GbfAddrWr[AW +: AW], 0);
    chk("t1_ptr2", GbfAddrWr[2*AW +: AW], 0);

    // Synchronous clear, then all three requesting: order 0,1,2,0.
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    chk("t2_sync_clr_ptrs", GbfAddrWr, 0);
    clear_logs();
    Req = 3'b111;
    begin
      int k = 0;
      while (gnt_q.size() < 4 && k < 2000) begin step(); k++; end
    end
    chk("t2_gnt_cnt", gnt_q.size(), 4);
    Req = '0;
    wait_idle("t2_idle");
    for (int k = 0; k < 4 && k < gnt_q.size(); k++)
      chk($sformatf("t2_gnt%0d", k), gnt_q[k], (k == 3) ? 0 : k);
    chk("t2_wr_cnt", wb_q.size(), 64);
    if (wb_q.size() >= 48) begin
      chk("t2_w16_buf", wb_q[16], 1);
      chk("t2_w16_addr", wa_q[16], 0);
      chk("t2_w47_buf", wb_q[47], 2);
      chk("t2_w47_addr", wa_q[47], 15);
    end
    chk("t2_ptr0", GbfAddrWr[0 +: AW], 32);
    chk("t2_ptr1", GbfAddrWr[AW +: AW], 16);
    chk("t2_ptr2", GbfAddrWr[2*AW +: AW], 16);

    // Async reset, then command stalled 5 cycles and gappy data.
    rst_n = 1'b0;
    #1;
    chk("t3_async_ptrs", GbfAddrWr, 0);
    step();
    rst_n = 1'b1;
    clear_logs();
    vld_mode = 1'b1;
    IfCmdRdy = 1'b0;
    Req = 3'b010;
    for (int c = 0; c < 5; c++) begin
      step();
      chk($sformatf("t3_cmdvld%0d", c), IfCmdVld, 1);
      chk($sformatf("t3_cmdid%0d", c), IfCmdId, 1);
      chk($sformatf("t3_datrdy%0d", c), IfDatRdy, 0);
    end
    Req = '0;
    IfCmdRdy = 1'b1;
    step();
    chk("t3_datrdy_xfer", IfDatRdy, 1);
    wait_writes(16, "t3");
    chk("t3_busy_at_last_wr", Busy, 1);
    chk("t3_beats", beat_ctr, 16);
    step();
    chk("t3_idle_after_done", Busy, 0);
    for (int k = 0; k < 16 && k < wb_q.size(); k++) begin
      chk($sformatf("t3_buf%0d", k), wb_q[k], 1);
      chk($sformatf("t3_addr%0d", k), wa_q[k], k);
      chk($sformatf("t3_dat%0d", k), wd_q[k], BASE | 64'(k));
    end

    // Reset pulse after 7 beats to buffer 1 (pointer starts at 16).
    clear_logs();
    vld_mode = 1'b0;
    Req = 3'b010;
    begin
      int k = 0;
      while (beat_ctr < 7 && k < 200) begin step(); k++; end
    end
    chk("t4_beats7", beat_ctr, 7);
    step();
    chk("t4_wr_cnt", wb_q.size(), 7);
    if (wb_q.size() >= 7) chk("t4_w6_addr", wa_q[6], 22);
    Reset = 1'b1;
    Req = 3'b011;
    step();
    Reset = 1'b0;
    chk("t4_busy", Busy, 0);
    chk("t4_grant", Grant, 0);
    chk("t4_en", GbfEnWr, 0);
    chk("t4_cmdvld", IfCmdVld, 0);
    chk("t4_datrdy", IfDatRdy, 0);
    chk("t4_ptrs", GbfAddrWr, 0);
    chk("t4_dat", GbfDatWr, 0);
    chk("t4_no_more_wr", wb_q.size(), 7);
    step();
    chk("t4_next_cmdvld", IfCmdVld, 1);
    chk("t4_next_id", IfCmdId, 0);
    chk("t4_next_grant", Grant, 3'b001);
    Req = '0;
    wait_idle("t4_idle");
    chk("never_multi_hot", multi_hot, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
